// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    localparam int unsigned DEFAULT_DIV_100MHZ_115200 = 868;
    localparam int unsigned MIN_DIV = 2;
    localparam int unsigned UART_FRAME_BITS = 10;

    // Dividers below MIN_DIV are clamped so every bit lasts at least two cycles.
    function automatic logic [31:0] eff_div(input logic [31:0] d);
        return (d < MIN_DIV) ? 32'(MIN_DIV) : d;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular-buffer FIFO with occupancy count and show-ahead read data.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];
    assign do_pop   = pop && !empty;
    // A simultaneous pop frees the slot being written, so full does not block it.
    assign do_push  = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO in front of a programmable-rate shifter.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_100MHZ_115200,
    parameter int          FIFO_DEPTH  = 16,
    parameter int          CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic             div_we,
    input  logic [31:0]      div_wdata,
    output logic [31:0]      div_rdata,
    output logic             ser_tx,
    output logic             busy,
    output logic [CNT_W-1:0] fifo_count
);
    localparam logic [2:0] LAST_BIT = 3'(UART_FRAME_BITS - 3);

    tx_state_t   state, state_d;
    logic [31:0] div_reg, frame_div, frame_div_d, bit_cnt, bit_cnt_d;
    logic [2:0]  bit_idx, bit_idx_d;
    logic [7:0]  shift_reg, shift_d, pop_data;
    logic        ser_d, push, pop, load, full, empty;
    logic [CNT_W-1:0] count_nxt;

    assign wr_ready  = !full;
    assign push      = wr_valid && wr_ready;
    assign div_rdata = div_reg;
    assign count_nxt = fifo_count + CNT_W'(push) - CNT_W'(pop);

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(wr_data),
        .pop      (pop),
        .pop_data (pop_data),
        .full     (full),
        .empty    (empty),
        .count    (fifo_count)
    );

    always_comb begin
        state_d     = state;
        ser_d       = ser_tx;
        bit_cnt_d   = bit_cnt;
        bit_idx_d   = bit_idx;
        shift_d     = shift_reg;
        frame_div_d = frame_div;
        load        = 1'b0;
        pop         = 1'b0;
        case (state)
            IDLE:  load = !empty;
            START: begin
                if (bit_cnt == 32'd0) begin
                    ser_d     = shift_reg[0];
                    bit_cnt_d = frame_div - 32'd1;
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end else begin
                    bit_cnt_d = bit_cnt - 32'd1;
                end
            end
            DATA: begin
                if (bit_cnt == 32'd0) begin
                    bit_cnt_d = frame_div - 32'd1;
                    if (bit_idx == LAST_BIT) begin
                        ser_d   = 1'b1;
                        state_d = STOP;
                    end else begin
                        shift_d   = {1'b0, shift_reg[7:1]};
                        ser_d     = shift_reg[1];
                        bit_idx_d = bit_idx + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt - 32'd1;
                end
            end
            STOP: begin
                if (bit_cnt == 32'd0) begin
                    // Chain straight into the next start bit when more data waits.
                    load    = !empty;
                    state_d = IDLE;
                end else begin
                    bit_cnt_d = bit_cnt - 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // The divider is sampled only here, so writes mid-frame wait for the next frame.
        if (load) begin
            pop         = 1'b1;
            shift_d     = pop_data;
            frame_div_d = eff_div(div_reg);
            bit_cnt_d   = eff_div(div_reg) - 32'd1;
            ser_d       = 1'b0;
            state_d     = START;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ser_tx    <= 1'b1;
            busy      <= 1'b0;
            div_reg   <= 32'(DEFAULT_DIV);
            frame_div <= eff_div(32'(DEFAULT_DIV));
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            state     <= state_d;
            ser_tx    <= ser_d;
            busy      <= (state_d != IDLE) || (count_nxt != '0);
            frame_div <= frame_div_d;
            bit_cnt   <= bit_cnt_d;
            bit_idx   <= bit_idx_d;
            shift_reg <= shift_d;
            if (div_we) div_reg <= div_wdata;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench: serial-line monitor against a byte scoreboard plus timing checks.
module tb_uart_tx_fifo;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       wr_data;
    logic             wr_valid;
    logic             wr_ready;
    logic             div_we;
    logic [31:0]      div_wdata;
    logic [31:0]      div_rdata;
    logic             ser_tx;
    logic             busy;
    logic [CNT_W-1:0] fifo_count;

    uart_tx_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .div_we    (div_we),
        .div_wdata (div_wdata),
        .div_rdata (div_rdata),
        .ser_tx    (ser_tx),
        .busy      (busy),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          nrx = 0;
    logic [7:0]  sb[$];
    int          starts[$];
    logic [31:0] m_div = 32'd868;
    logic [31:0] edge_div = 32'd868;
    logic        rst_hit = 1'b0;

    // Reference divider register; edge_div holds the clamped value seen at the last edge.
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_hit  <= rst;
        edge_div <= (m_div < 32'd2) ? 32'd2 : m_div;
        if (rst) m_div <= 32'd868;
        else if (div_we) m_div <= div_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Line monitor: every cycle of a frame is compared with the expected level.
    initial begin : mon
        logic [9:0] bits;
        logic [7:0] got, exp;
        int         d;
        bit         ok, ab, have;
        forever begin
            @(negedge clk);
            if (ser_tx === 1'b0 && !rst) begin
                starts.push_back(cyc);
                d    = int'(edge_div);
                have = (sb.size() != 0);
                exp  = 8'h00;
                if (have) exp = sb.pop_front();
                bits = {1'b1, exp, 1'b0};
                ok = 1'b1; ab = 1'b0; got = 8'h00;
                for (int n = 0; n < 10 * d; n++) begin
                    if (n != 0) @(negedge clk);
                    if (rst_hit) begin ab = 1'b1; break; end
                    if (ser_tx !== bits[n / d]) ok = 1'b0;
                    if (n / d >= 1 && n / d <= 8 && n % d == d / 2) got[n / d - 1] = ser_tx;
                end
                if (!ab) begin
                    chk("start_expected", 32'(have), 32'd1);
                    if (have) begin
                        chk("rx_byte", 32'(got), 32'(exp));
                        chk("bit_timing", 32'(ok), 32'd1);
                        nrx++;
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit exp_acc);
        bit acc;
        wr_data  = b;
        wr_valid = 1'b1;
        acc      = wr_ready;
        @(negedge clk);
        wr_valid = 1'b0;
        chk("wr_accept", 32'(acc), 32'(exp_acc));
        if (exp_acc) sb.push_back(b);
    endtask

    task automatic wdiv(input logic [31:0] v);
        div_we    = 1'b1;
        div_wdata = v;
        @(negedge clk);
        div_we = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int fall);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin @(negedge clk); n++; end
        chk("idle_reached", 32'(busy), 32'd0);
        fall = cyc;
    endtask

    task automatic wait_start(input int budget);
        int n = 0;
        while (starts.size() == 0 && n < budget) begin @(negedge clk); n++; end
        chk("start_seen", 32'(starts.size() != 0), 32'd1);
    endtask

    typedef struct {
        logic [31:0] div;
        logic [7:0]  b;
        logic [31:0] rd;
        int          len;
    } vec_t;

    initial begin
        vec_t  tv[5];
        string msg;
        int    acc_cyc, s, fall, base, peak, lows;

        tv[0] = '{32'd1, 8'hA3, 32'd1, 20};
        tv[1] = '{32'd0, 8'h5A, 32'd0, 20};
        tv[2] = '{32'd2, 8'h3C, 32'd2, 20};
        tv[3] = '{32'd3, 8'hC3, 32'd3, 30};
        tv[4] = '{32'd5, 8'h0F, 32'd5, 50};
        msg = "92345679";

        rst = 1'b1; wr_valid = 1'b0; wr_data = 8'h00; div_we = 1'b0; div_wdata = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ser_tx", 32'(ser_tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_div", div_rdata, 32'd868);

        // Single byte at the default rate.
        send(8'h55, 1'b1);
        acc_cyc = cyc;
        chk("pre_start_ser", 32'(ser_tx), 32'd1);
        chk("pre_start_count", 32'(fifo_count), 32'd1);
        chk("pre_start_busy", 32'(busy), 32'd1);
        wait_start(10);
        s = starts[0];
        chk("start_latency", 32'(s - acc_cyc), 32'd1);
        while (cyc < s + 8679) @(negedge clk);
        chk("busy_last_cycle", 32'(busy), 32'd1);
        @(negedge clk);
        chk("busy_clear_8680", 32'(busy), 32'd0);

        // Eight back-to-back frames.
        wdiv(32'd100);
        starts.delete();
        base = nrx; peak = 0;
        for (int i = 0; i < 8; i++) begin
            send(msg[i], 1'b1);
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        chk("fifo_peak", 32'(peak), 32'd7);
        wait_idle(9000, fall);
        chk("rx_count8", 32'(nrx - base), 32'd8);
        for (int i = 1; i < 8; i++) chk("frame_spacing", 32'(starts[i] - starts[i-1]), 32'd1000);
        chk("last_frame_len", 32'(fall - starts[7]), 32'd1000);

        // Fill while the line is busy; the 17th push is dropped.
        wdiv(32'd16);
        base = nrx;
        send(8'h00, 1'b1);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 17; i++) send(8'(i + 'h60), i < 16);
        chk("full_count", 32'(fifo_count), 32'd16);
        chk("full_wr_ready", 32'(wr_ready), 32'd0);
        wait_idle(17 * 160 + 300, fall);
        chk("rx_count17", 32'(nrx - base), 32'd17);

        // Divider table, including clamped values.
        for (int i = 0; i < 5; i++) begin
            wdiv(tv[i].div);
            chk("div_rdata", div_rdata, tv[i].rd);
            starts.delete();
            send(tv[i].b, 1'b1);
            wait_idle(200, fall);
            chk("frame_len", 32'(fall - starts[0]), 32'(tv[i].len));
        end

        // Divider write in the middle of a frame applies to the next one.
        wdiv(32'd868);
        starts.delete();
        send(8'h41, 1'b1);
        send(8'h42, 1'b1);
        wait_start(20);
        s = starts[0];
        while (cyc < s + 4 * 868 + 434) @(negedge clk);
        wdiv(32'd100);
        wait_idle(12000, fall);
        chk("old_div_frame", 32'(starts[1] - s), 32'd8680);
        chk("new_div_frame", 32'(fall - starts[1]), 32'd1000);
        chk("div_rdata_100", div_rdata, 32'd100);

        // Reset during data bit 4 with three bytes queued.
        starts.delete();
        send(8'h11, 1'b1); send(8'h22, 1'b1); send(8'h33, 1'b1); send(8'h44, 1'b1);
        wait_start(20);
        s = starts[0];
        while (cyc < s + 550) @(negedge clk);
        chk("queued_before_rst", 32'(fifo_count), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        chk("mid_rst_ser", 32'(ser_tx), 32'd1);
        chk("mid_rst_count", 32'(fifo_count), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(wr_ready), 32'd1);
        chk("mid_rst_div", div_rdata, 32'd868);
        lows = 0;
        repeat (20000) begin
            @(negedge clk);
            if (ser_tx !== 1'b1) lows++;
        end
        chk("quiet_line", 32'(lows), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
